vga_vram_scheduler: RTL and testbench

- Shares the single clk_vga-side read port of the VGA frame VRAM (64K x 8, registered read, 1-cycle latency) between the display scan-out and a burst capture reader (screenshot/debug readback).
- Display fetch has absolute priority inside a configurable fetch window. Capture reads are scheduled only in the free slots outside that window, one read at a time, with a valid/ready output handshake.
- Sits between the VGA timing counters and the VRAM port B address input.

---
 rtl/vga_vram_scheduler.sv | 105 ++++++++++
 tb/tb_vga_vram_scheduler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_vram_scheduler.sv
// Arbitrates the clk_vga-side VRAM read port between display scan-out and a
// burst capture reader. Display fetch owns the port inside its window; capture reads use the remaining slots.
module vga_vram_scheduler #(
  parameter int unsigned HF_START    = 285,
  parameter int unsigned HF_END      = 797,
  parameter int unsigned VF_START    = 45,
  parameter int unsigned VF_END      = 524,
  parameter bit          VBLANK_ONLY = 1'b0
) (
  input  logic        clk_vga,
  input  logic        reset,
  input  logic [9:0]  vga_hcnt,
  input  logic [9:0]  vga_vcnt,
  input  logic [15:0] disp_addr,
  output logic [15:0] vram_addr_b,
  input  logic [7:0]  vram_q_b,
  input  logic        cap_start,
  input  logic [15:0] cap_addr,
  input  logic [8:0]  cap_len,
  output logic        cap_busy,
  output logic        cap_rvalid,
  input  logic        cap_ready,
  output logic [7:0]  cap_rdata,
  output logic        cap_done
);

  typedef enum logic [1:0] {IDLE, ARB, LAT, HOLD} state_t;

  localparam logic [9:0] H_LO = 10'(HF_START);
  localparam logic [9:0] H_HI = 10'(HF_END);
  localparam logic [9:0] V_LO = 10'(VF_START);
  localparam logic [9:0] V_HI = 10'(VF_END);

  state_t      state, state_nxt;
  logic [15:0] cur_addr;
  logic [8:0]  remaining;
  logic        h_in, v_in, fetch_win, port_free;
  logic        start_ok, last_byte;

  assign h_in      = (vga_hcnt >= H_LO) && (vga_hcnt <= H_HI);
  assign v_in      = (vga_vcnt >= V_LO) && (vga_vcnt <= V_HI);
  assign fetch_win = h_in && v_in;
  assign port_free = VBLANK_ONLY ? !v_in : !fetch_win;

  // The cap_done cycle is already IDLE, but a start there still counts as "busy".
  assign start_ok  = cap_start && !cap_done;
  assign last_byte = (remaining == 9'd1);

  assign cap_busy    = (state != IDLE);
  assign vram_addr_b = ((state == ARB) && port_free) ? cur_addr : disp_addr;

  always_ff @(posedge clk_vga) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: next state is defaulted to the current state before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = ARB;
      ARB:     if (port_free) state_nxt = LAT;
      LAT:     state_nxt = HOLD;
      HOLD:    if (cap_ready) state_nxt = last_byte ? IDLE : ARB;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_vga) begin
    if (reset) begin
      cur_addr   <= 16'h0000;
      remaining  <= 9'd0;
      cap_rdata  <= 8'h00;
      cap_rvalid <= 1'b0;
      cap_done   <= 1'b0;
    end else begin
      cap_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            cur_addr  <= cap_addr;
            remaining <= (cap_len == 9'd0) ? 9'd256 : cap_len;
          end
        end
        LAT: begin
          cap_rdata  <= vram_q_b;
          cap_rvalid <= 1'b1;
        end
        HOLD: begin
          if (cap_ready) begin
            cur_addr   <= cur_addr + 16'd1;
            remaining  <= remaining - 9'd1;
            cap_rvalid <= 1'b0;
            cap_done   <= last_byte;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_vram_scheduler.sv
// Scoreboard bench for vga_vram_scheduler: expected read addresses and bytes
// are queued at burst start; negedge monitors pop and compare.
module tb_vga_vram_scheduler;

  logic        clk_vga = 1'b0;
  logic        reset;
  logic [9:0]  vga_hcnt, vga_vcnt;
  logic [15:0] disp_addr;
  logic        cap_start, cap_start_vb, cap_ready;
  logic [15:0] cap_addr;
  logic [8:0]  cap_len;

  logic [15:0] vram_addr_b, vram_addr_b_vb;
  logic [7:0]  vram_q_b, vram_q_b_vb;
  logic        cap_busy, cap_rvalid, cap_done;
  logic        cap_busy_vb, cap_rvalid_vb, cap_done_vb;
  logic [7:0]  cap_rdata, cap_rdata_vb;

  logic [7:0]  mem [65536];

  logic [15:0] exp_addr_q[$], exp_vb_addr_q[$];
  logic [7:0]  exp_data_q[$], exp_vb_data_q[$];

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int done_vb_cnt = 0;
  bit free_run = 1'b0;
  bit seen_rd = 1'b0, seen_vb_rd = 1'b0;
  logic [9:0] first_h, first_v, first_vb_v;

  always #5 clk_vga = ~clk_vga;

  assign disp_addr = {6'h2F, vga_hcnt};

  always @(posedge clk_vga) begin
    vram_q_b    <= mem[vram_addr_b];
    vram_q_b_vb <= mem[vram_addr_b_vb];
  end

  vga_vram_scheduler u_dut (
    .clk_vga(clk_vga), .reset(reset), .vga_hcnt(vga_hcnt), .vga_vcnt(vga_vcnt),
    .disp_addr(disp_addr), .vram_addr_b(vram_addr_b), .vram_q_b(vram_q_b),
    .cap_start(cap_start), .cap_addr(cap_addr), .cap_len(cap_len),
    .cap_busy(cap_busy), .cap_rvalid(cap_rvalid), .cap_ready(cap_ready),
    .cap_rdata(cap_rdata), .cap_done(cap_done)
  );

  vga_vram_scheduler #(.VBLANK_ONLY(1'b1)) u_vb (
    .clk_vga(clk_vga), .reset(reset), .vga_hcnt(vga_hcnt), .vga_vcnt(vga_vcnt),
    .disp_addr(disp_addr), .vram_addr_b(vram_addr_b_vb), .vram_q_b(vram_q_b_vb),
    .cap_start(cap_start_vb), .cap_addr(cap_addr), .cap_len(cap_len),
    .cap_busy(cap_busy_vb), .cap_rvalid(cap_rvalid_vb), .cap_ready(cap_ready),
    .cap_rdata(cap_rdata_vb), .cap_done(cap_done_vb)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s", name);
  endtask

  function automatic bit in_win(input logic [9:0] h, input logic [9:0] v);
    return (h >= 10'd285) && (h <= 10'd797) && (v >= 10'd45) && (v <= 10'd524);
  endfunction

  // Main instance monitor: capture-read addresses, returned bytes, done pulses.
  always @(negedge clk_vga) begin
    if (!reset) begin
      if (vram_addr_b !== disp_addr) begin
        if (!seen_rd) begin
          seen_rd = 1'b1; first_h = vga_hcnt; first_v = vga_vcnt;
        end
        check("rd_outside_window", 32'(in_win(vga_hcnt, vga_vcnt)), 32'd0);
        if (exp_addr_q.size() == 0) fail_now("unexpected_capture_read");
        else check("rd_addr", 32'(vram_addr_b), 32'(exp_addr_q.pop_front()));
      end
      if (cap_rvalid && cap_ready) begin
        if (exp_data_q.size() == 0) fail_now("unexpected_byte");
        else check("rd_data", 32'(cap_rdata), 32'(exp_data_q.pop_front()));
      end
      if (cap_done) begin
        done_cnt++;
        check("busy_low_on_done", 32'(cap_busy), 32'd0);
      end
    end
  end

  // Blanking-only instance monitor.
  always @(negedge clk_vga) begin
    if (!reset) begin
      if (vram_addr_b_vb !== disp_addr) begin
        if (!seen_vb_rd) begin
          seen_vb_rd = 1'b1; first_vb_v = vga_vcnt;
        end
        check("vb_rd_in_vblank", 32'(vga_vcnt >= 10'd45 && vga_vcnt <= 10'd524), 32'd0);
        if (exp_vb_addr_q.size() == 0) fail_now("vb_unexpected_read");
        else check("vb_rd_addr", 32'(vram_addr_b_vb), 32'(exp_vb_addr_q.pop_front()));
      end
      if (cap_rvalid_vb && cap_ready) begin
        if (exp_vb_data_q.size() == 0) fail_now("vb_unexpected_byte");
        else check("vb_rd_data", 32'(cap_rdata_vb), 32'(exp_vb_data_q.pop_front()));
      end
      if (cap_done_vb) done_vb_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk_vga);
    #1;
    if (free_run) begin
      if (vga_hcnt == 10'd799) begin
        vga_hcnt = 10'd0;
        vga_vcnt = (vga_vcnt == 10'd524) ? 10'd0 : vga_vcnt + 10'd1;
      end else begin
        vga_hcnt = vga_hcnt + 10'd1;
      end
    end
  endtask

  task automatic start_burst(input logic [15:0] addr, input logic [8:0] len, input bit vb);
    int n;
    logic [15:0] a;
    n = (len == 9'd0) ? 256 : int'(len);
    for (int i = 0; i < n; i++) begin
      a = addr + 16'(i);
      if (vb) begin exp_vb_addr_q.push_back(a); exp_vb_data_q.push_back(mem[a]); end
      else    begin exp_addr_q.push_back(a);    exp_data_q.push_back(mem[a]);    end
    end
    cap_addr = addr;
    cap_len  = len;
    if (vb) cap_start_vb = 1'b1; else cap_start = 1'b1;
    tick();
    cap_start = 1'b0;
    cap_start_vb = 1'b0;
  endtask

  task automatic wait_rvalid(input string name);
    int n = 0;
    while (!cap_rvalid && n < 2000) begin tick(); n++; end
    if (!cap_rvalid) fail_now(name);
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    while (cap_busy && n < limit) begin tick(); n++; end
    if (cap_busy) fail_now(name);
    tick();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin : stim
    int d0, lat;
    logic [7:0] held;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
    mem[16'h1234] = 8'h2A;

    reset = 1'b1; cap_start = 1'b0; cap_start_vb = 1'b0; cap_ready = 1'b1;
    cap_addr = 16'h0; cap_len = 9'd1; vga_hcnt = 10'd100; vga_vcnt = 10'd10;
    repeat (3) tick();
    check("rst_busy", 32'(cap_busy), 32'd0);
    check("rst_rvalid", 32'(cap_rvalid), 32'd0);
    check("rst_done", 32'(cap_done), 32'd0);
    check("rst_rdata", 32'(cap_rdata), 32'h00);
    check("rst_addr_mux", 32'(vram_addr_b), 32'(disp_addr));
    reset = 1'b0;
    tick();

    // Single byte in horizontal blanking: 3-cycle latency, preloaded 8'h2A.
    d0 = done_cnt;
    start_burst(16'h1234, 9'd1, 1'b0);
    check("busy_after_start", 32'(cap_busy), 32'd1);
    lat = 1;
    while (!cap_rvalid && lat < 20) begin tick(); lat++; end
    check("first_rvalid_latency", 32'(lat), 32'd3);
    check("first_rdata", 32'(cap_rdata), 32'h2A);
    wait_idle("single_idle_timeout", 20);
    check("single_done_count", 32'(done_cnt - d0), 32'd1);

    // Burst started inside the fetch window waits until hcnt 798.
    free_run = 1'b1; vga_hcnt = 10'd290; vga_vcnt = 10'd100;
    seen_rd = 1'b0; d0 = done_cnt;
    start_burst(16'h0100, 9'd4, 1'b0);
    wait_idle("window_idle_timeout", 2000);
    check("window_first_rd_h", 32'(first_h), 32'd798);
    check("window_first_rd_v", 32'(first_v), 32'd100);
    check("window_done_count", 32'(done_cnt - d0), 32'd1);
    check("window_queue_empty", 32'(exp_addr_q.size() + exp_data_q.size()), 32'd0);

    // Backpressure on the second of three bytes.
    free_run = 1'b0; vga_hcnt = 10'd100; vga_vcnt = 10'd10;
    cap_ready = 1'b0;
    start_burst(16'h0400, 9'd3, 1'b0);
    wait_rvalid("bp_byte1_timeout");
    cap_ready = 1'b1;
    tick();
    cap_ready = 1'b0;
    wait_rvalid("bp_byte2_timeout");
    held = cap_rdata;
    check("bp_byte2_value", 32'(held), 32'(mem[16'h0401]));
    repeat (10) begin
      tick();
      check("bp_rdata_stable", 32'(cap_rdata), 32'(held));
      check("bp_rvalid_held", 32'(cap_rvalid), 32'd1);
    end
    cap_ready = 1'b1;
    wait_idle("bp_idle_timeout", 50);
    check("bp_queue_empty", 32'(exp_data_q.size()), 32'd0);

    // Length 0 means 256 bytes; address wraps past 16'hFFFF.
    free_run = 1'b1; vga_hcnt = 10'd0; vga_vcnt = 10'd0;
    d0 = done_cnt;
    start_burst(16'hFFFF, 9'd0, 1'b0);
    wait_idle("wrap_idle_timeout", 4000);
    check("wrap_done_count", 32'(done_cnt - d0), 32'd1);
    check("wrap_queue_empty", 32'(exp_addr_q.size() + exp_data_q.size()), 32'd0);

    // Blanking-only instance: no read on active lines, first read at vcnt 0.
    vga_hcnt = 10'd10; vga_vcnt = 10'd100;
    seen_vb_rd = 1'b0; d0 = done_vb_cnt;
    start_burst(16'h3000, 9'd2, 1'b1);
    repeat (2000) tick();
    check("vb_no_read_active", 32'(seen_vb_rd), 32'd0);
    vga_hcnt = 10'd0; vga_vcnt = 10'd523;
    begin
      int n = 0;
      while (cap_busy_vb && n < 3000) begin tick(); n++; end
      if (cap_busy_vb) fail_now("vb_idle_timeout");
    end
    tick();
    check("vb_first_rd_v", 32'(first_vb_v), 32'd0);
    check("vb_done_count", 32'(done_vb_cnt - d0), 32'd1);

    // Reset while a byte is held drops it without cap_done.
    free_run = 1'b0; vga_hcnt = 10'd100; vga_vcnt = 10'd10;
    cap_ready = 1'b0; d0 = done_cnt;
    start_burst(16'h0800, 9'd2, 1'b0);
    wait_rvalid("rst_hold_timeout");
    reset = 1'b1;
    tick();
    check("midrst_rvalid", 32'(cap_rvalid), 32'd0);
    check("midrst_busy", 32'(cap_busy), 32'd0);
    reset = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    tick();
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    cap_ready = 1'b1;
    start_burst(16'h0900, 9'd1, 1'b0);
    wait_idle("post_rst_idle_timeout", 20);
    check("post_rst_done", 32'(done_cnt - d0), 32'd1);
    check("final_queue_empty", 32'(exp_addr_q.size() + exp_data_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
